conv_loop_scheduler: RTL
========================

CONV_LOOP_SCHEDULER -- requirements
Module: conv_loop_scheduler

Interface
REQ-001 SHALL have parameter MAC_ROW, default 16, PE rows (input-channel lanes).
REQ-002 SHALL have parameter MAC_COL, default 16, PE columns (output-channel lanes).
REQ-003 SHALL have parameter IFMAP_CHANNEL_NUM, default 32, input channels; a multiple of MAC_ROW.
REQ-004 SHALL have parameter OFMAP_CHANNEL_NUM, default 64, output channels; a multiple of MAC_COL.
REQ-005 SHALL have parameter WEIGHT_WIDTH, default 3, kernel width.
REQ-006 SHALL have parameter WEIGHT_HEIGHT, default 3, kernel height.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, begin one full layer.
REQ-010 SHALL have port abort, input, 1, synchronous cancel.
REQ-011 SHALL have port weight_load_done, input, 1, pulse: weight tile loaded.
REQ-012 SHALL have port pass_done, input, 1, pulse: IFMap controller finished its output-plane sweep.
REQ-013 SHALL have port weight_load_start, output, 1, pulse: load weight tile.
REQ-014 SHALL have port ifmap_start, output, 1, pulse to the IFMap controller ifmap_start_in.
REQ-015 SHALL have ports I_CH_MAC_ROW_count, W_W_count, W_H_count and O_CH_MAC_COL_count, output, 32 each, loop indices.
REQ-016 SHALL have port psum_first, output, 1, high during the first accumulation pass of an output-channel group.
REQ-017 SHALL have ports busy, output, 1, and done, output, 1; done is a one-cycle completion pulse.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD_W, WAIT_W, START_IF, WAIT_IF, NEXT and FIN; all outputs are registered.
REQ-019 SHALL move IDLE->LOAD_W when start=1, with all counts zeroed.
REQ-020 SHALL pass through LOAD_W in one cycle with weight_load_start=1, then go to WAIT_W.
REQ-021 SHALL go WAIT_W->START_IF when weight_load_done=1.
REQ-022 SHALL pass through START_IF in one cycle with ifmap_start=1, then go to WAIT_IF.
REQ-023 SHALL go WAIT_IF->NEXT when pass_done=1.
REQ-024 SHALL, in NEXT (one cycle), advance the loop nest (innermost to outermost): I_CH_MAC_ROW_count over 0..IFMAP_CHANNEL_NUM/MAC_ROW-1, then W_W_count over 0..WEIGHT_WIDTH-1, then W_H_count over 0..WEIGHT_HEIGHT-1, then O_CH_MAC_COL_count over 0..OFMAP_CHANNEL_NUM/MAC_COL-1. Each index wraps to 0 and carries into the next outer index. NEXT then goes to LOAD_W.
REQ-025 SHALL, in NEXT when all four counts are at their maximums, hold the counts and go to FIN instead.
REQ-026 SHALL pass through FIN in one cycle with done=1, then go to IDLE with counts cleared to 0.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL drive psum_first=1 exactly when I_CH_MAC_ROW_count, W_W_count and W_H_count are all 0 and busy=1.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL ignore weight_load_done outside WAIT_W and pass_done outside WAIT_IF.
REQ-031 SHALL treat a pass_done coincident with ifmap_start as not yet received.
REQ-032 SHALL give abort=1 priority over every transition: in any non-IDLE state, next state is IDLE, counts are 0, and no done pulse is issued. In IDLE, abort=1 together with start=1 keeps the FSM in IDLE.
REQ-033 SHALL assert weight_load_start, ifmap_start and done for exactly one cycle per occurrence; they are mutually exclusive.
REQ-034 SHALL issue exactly (IFMAP_CHANNEL_NUM/MAC_ROW)*WEIGHT_WIDTH*WEIGHT_HEIGHT*(OFMAP_CHANNEL_NUM/MAC_COL) ifmap_start pulses per layer, which is 72 at default parameters.
REQ-035 SHALL hold all counts stable from START_IF through WAIT_IF.

Reset
REQ-036 SHALL, while rstn=0, immediately force the FSM to IDLE and all outputs and counts to 0, independent of clk.
REQ-037 SHALL, on reset mid-layer, discard all progress; after release it waits in IDLE for a new start.

Verification
REQ-038 SHALL be verified by a bench covering these scenarios:
- Defaults, start; respond to each weight_load_start with weight_load_done 2 cycles later and to each ifmap_start with pass_done 5 cycles later -> 72 ifmap_start pulses, one done, busy falls the cycle after done.
- Index order: first three passes -> (I_CH,W_W,W_H,O_CH) = (0,0,0,0), (1,0,0,0), (0,1,0,0); pass 19 -> (0,0,0,1); psum_first=1 only on passes 1, 19, 37, 55.
- Stray pass_done and weight_load_done pulses during IDLE and WAIT_W -> no state change and no extra pulses.
- abort in WAIT_IF at pass 10 -> next cycle busy=0, counts 0, no done; a following start restarts at (0,0,0,0).
- rstn low for 1 cycle in WAIT_W -> outputs 0 asynchronously; start asserted during busy is ignored and the pulse count stays 72.
- MAC_ROW=IFMAP_CHANNEL_NUM=16, WEIGHT 1x1, OFMAP_CHANNEL_NUM=MAC_COL=16 -> exactly one pass, psum_first=1, done after the first NEXT.

Source files
------------

// File: rtl/conv_loop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : conv_loop_scheduler
//  Purpose  : Sequences one convolution layer over a 4-deep loop nest
//             (input-channel group, kernel column, kernel row, output-channel
//             group). For every loop point it requests a weight tile load,
//             waits for it, launches an IFMap output-plane sweep, waits for
//             that to finish, then advances the loop nest.
//  Ports    :
//    clk, rstn                 - clock, asynchronous active-low reset
//    start                     - begin one full layer (ignored while busy)
//    abort                     - synchronous cancel, highest priority
//    weight_load_done          - pulse: weight tile loaded
//    pass_done                 - pulse: IFMap sweep finished
//    weight_load_start         - pulse: load the weight tile for this point
//    ifmap_start               - pulse: launch the IFMap sweep
//    I_CH_MAC_ROW_count ..     - current loop indices (innermost first:
//    O_CH_MAC_COL_count          I_CH, W_W, W_H, O_CH)
//    psum_first                - first accumulation pass of an O_CH group
//    busy, done                - layer in progress / one-cycle completion
//  Revision : 1.0 - initial release
// ============================================================================
module conv_loop_scheduler #(
  parameter int MAC_ROW           = 16,
  parameter int MAC_COL           = 16,
  parameter int IFMAP_CHANNEL_NUM = 32,
  parameter int OFMAP_CHANNEL_NUM = 64,
  parameter int WEIGHT_WIDTH      = 3,
  parameter int WEIGHT_HEIGHT     = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        weight_load_done,
  input  logic        pass_done,
  output logic        weight_load_start,
  output logic        ifmap_start,
  output logic [31:0] I_CH_MAC_ROW_count,
  output logic [31:0] W_W_count,
  output logic [31:0] W_H_count,
  output logic [31:0] O_CH_MAC_COL_count,
  output logic        psum_first,
  output logic        busy,
  output logic        done
);

  // Terminal value of each loop index.
  localparam logic [31:0] ICH_MAX = 32'(IFMAP_CHANNEL_NUM / MAC_ROW - 1);
  localparam logic [31:0] WW_MAX  = 32'(WEIGHT_WIDTH - 1);
  localparam logic [31:0] WH_MAX  = 32'(WEIGHT_HEIGHT - 1);
  localparam logic [31:0] OCH_MAX = 32'(OFMAP_CHANNEL_NUM / MAC_COL - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    WAIT_W   = 3'd2,
    START_IF = 3'd3,
    WAIT_IF  = 3'd4,
    NEXT     = 3'd5,
    FIN      = 3'd6
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] ich_n;
  logic [31:0] ww_n;
  logic [31:0] wh_n;
  logic [31:0] och_n;
  logic        last_point;

  assign last_point = (I_CH_MAC_ROW_count == ICH_MAX) &&
                      (W_W_count          == WW_MAX)  &&
                      (W_H_count          == WH_MAX)  &&
                      (O_CH_MAC_COL_count == OCH_MAX);

  // Next-state and next-index logic.
  always_comb begin
    state_n = state;
    ich_n   = I_CH_MAC_ROW_count;
    ww_n    = W_W_count;
    wh_n    = W_H_count;
    och_n   = O_CH_MAC_COL_count;

    if (abort) begin
      // Abort wins over everything, including a coincident start in IDLE.
      state_n = IDLE;
      ich_n   = '0;
      ww_n    = '0;
      wh_n    = '0;
      och_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD_W;
            ich_n   = '0;
            ww_n    = '0;
            wh_n    = '0;
            och_n   = '0;
          end
        end
        LOAD_W: state_n = WAIT_W;
        WAIT_W: begin
          if (weight_load_done) state_n = WAIT_W == state ? START_IF : state;
        end
        // pass_done is only looked at in WAIT_IF, so a pass_done that
        // coincides with the ifmap_start cycle is not treated as received.
        START_IF: state_n = WAIT_IF;
        WAIT_IF: begin
          if (pass_done) state_n = NEXT;
        end
        NEXT: begin
          if (last_point) begin
            // Indices hold at their maxima through FIN.
            state_n = FIN;
          end else begin
            state_n = LOAD_W;
            // Odometer-style carry chain, innermost index first.
            if (I_CH_MAC_ROW_count != ICH_MAX) begin
              ich_n = I_CH_MAC_ROW_count + 32'd1;
            end else begin
              ich_n = '0;
              if (W_W_count != WW_MAX) begin
                ww_n = W_W_count + 32'd1;
              end else begin
                ww_n = '0;
                if (W_H_count != WH_MAX) begin
                  wh_n = W_H_count + 32'd1;
                end else begin
                  wh_n  = '0;
                  och_n = O_CH_MAC_COL_count + 32'd1;
                end
              end
            end
          end
        end
        FIN: begin
          state_n = IDLE;
          ich_n   = '0;
          ww_n    = '0;
          wh_n    = '0;
          och_n   = '0;
        end
        default: begin
          state_n = IDLE;
          ich_n   = '0;
          ww_n    = '0;
          wh_n    = '0;
          och_n   = '0;
        end
      endcase
    end
  end

  // State register. Outputs are registered by decoding the next state, so
  // each pulse output is high exactly for the cycle spent in its state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      I_CH_MAC_ROW_count <= '0;
      W_W_count          <= '0;
      W_H_count          <= '0;
      O_CH_MAC_COL_count <= '0;
      weight_load_start  <= 1'b0;
      ifmap_start        <= 1'b0;
      done               <= 1'b0;
      busy               <= 1'b0;
      psum_first         <= 1'b0;
    end else begin
      state              <= state_n;
      I_CH_MAC_ROW_count <= ich_n;
      W_W_count          <= ww_n;
      W_H_count          <= wh_n;
      O_CH_MAC_COL_count <= och_n;
      weight_load_start  <= (state_n == LOAD_W);
      ifmap_start        <= (state_n == START_IF);
      done               <= (state_n == FIN);
      busy               <= (state_n != IDLE);
      psum_first         <= (state_n != IDLE) && (ich_n == '0) &&
                            (ww_n == '0) && (wh_n == '0);
    end
  end

endmodule
`default_nettype wire
